// File: rtl/display_pkg.sv
// Shared constants and types for the 7-segment display path.
// Holds default timing constants (sized for a 100 MHz core clock), the
// freeze-state encoding used by display_capture_ctrl and the decoder
// wrapper, and a helper that sizes down-counters.
package display_pkg;

  // Core clocks per scan-clock period (1 kHz at 100 MHz).
  localparam int unsigned REFRESH_DIV_DEF = 100000;
  // Cycles the synchronized button must hold a new level (10 ms).
  localparam int unsigned DEB_CYCLES_DEF  = 1000000;
  // Stretch length of the update indicator (50 ms).
  localparam int unsigned LED_CYCLES_DEF  = 5000000;

  typedef enum logic {
    LIVE = 1'b0,
    HOLD = 1'b1
  } frz_state_e;

  // Bits needed for a counter spanning 0 .. n-1, never less than 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, debounce counter and
// press pulse.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   btn_i    in   raw asynchronous button
//   press_o  out  one-cycle pulse when the debounced level rises
module btn_debounce
  import display_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNT_W = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only advances while the synchronized input disagrees with
  // the accepted level; any return to agreement drops it back to zero.
  // Acceptance happens on the edge where the counter already sits at its
  // last value, i.e. after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
    end else begin
      sync1_q       <= btn_i;
      sync2_q       <= sync1_q;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
    end
  end

  // High for the one cycle right after the accepted level goes 0 -> 1.
  assign press_o = stable_q & ~stable_prev_q;

endmodule

// File: rtl/display_capture_ctrl.sv
// Capture/freeze front end for the 7-segment scanning decoder.
// Latches writeback results aimed at a switch-selected register, exposes
// one 16-bit half to the decoder, generates the slow scan clock, and lets a
// debounced button freeze the display while the core keeps running.
// Ports:
//   clk         in   core clock
//   reset       in   asynchronous active-low reset
//   RegWriteW   in   writeback register-write enable
//   WA3W        in   writeback destination register
//   ResultW     in   writeback data
//   sel_reg     in   register to monitor
//   sel_half    in   0 = low half, 1 = high half of the captured word
//   hold_btn    in   raw freeze button
//   disp_value  out  value for the decoder
//   scan_clk    out  50% duty square wave, period REFRESH_DIV clocks
//   frozen      out  display held
//   update_led  out  stretched pulse on each capture
module display_capture_ctrl
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEF,  // even, >= 2
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned LED_CYCLES  = LED_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteW,
  input  logic [3:0]  WA3W,
  input  logic [31:0] ResultW,
  input  logic [3:0]  sel_reg,
  input  logic        sel_half,
  input  logic        hold_btn,
  output logic [15:0] disp_value,
  output logic        scan_clk,
  output logic        frozen,
  output logic        update_led
);

  localparam int unsigned SCAN_W = cnt_width(REFRESH_DIV / 2);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV / 2 - 1);
  localparam int unsigned LED_W = cnt_width(LED_CYCLES);
  localparam logic [LED_W-1:0] LED_LAST = LED_W'(LED_CYCLES - 1);

  // ---------------- scan clock prescaler (never gated) ----------------
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic              scan_clk_q, scan_clk_d;

  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    scan_clk_d = scan_clk_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_clk_d = ~scan_clk_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_q <= '0;
      scan_clk_q <= 1'b0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_clk_q <= scan_clk_d;
    end
  end

  assign scan_clk = scan_clk_q;

  // ---------------- freeze button ----------------
  logic press;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_hold_btn (
    .clk     (clk),
    .rst_n   (reset),
    .btn_i   (hold_btn),
    .press_o (press)
  );

  // ---------------- freeze FSM ----------------
  frz_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (press) begin
      state_d = (state_q == LIVE) ? HOLD : LIVE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= LIVE;
    else        state_q <= state_d;
  end

  assign frozen = (state_q == HOLD);

  // ---------------- capture ----------------
  // Uses the current state, so a press arriving with a matching write
  // still lets that write through; HOLD only blocks from the next edge.
  logic        capture;
  logic [31:0] result_q, result_d;

  assign capture = RegWriteW && (WA3W == sel_reg) && (state_q == LIVE);

  always_comb begin
    result_d = result_q;
    if (capture) result_d = ResultW;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) result_q <= '0;
    else        result_q <= result_d;
  end

  assign disp_value = sel_half ? result_q[31:16] : result_q[15:0];

  // ---------------- update LED stretcher ----------------
  // The LED stays lit through the cycle in which the counter sits at zero,
  // giving exactly LED_CYCLES lit cycles per capture.
  logic [LED_W-1:0] led_cnt_q, led_cnt_d;
  logic             led_q, led_d;

  always_comb begin
    led_cnt_d = led_cnt_q;
    led_d     = led_q;
    if (capture) begin
      led_cnt_d = LED_LAST;
      led_d     = 1'b1;
    end else if (led_cnt_q != '0) begin
      led_cnt_d = led_cnt_q - LED_W'(1);
    end else begin
      led_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_cnt_q <= '0;
      led_q     <= 1'b0;
    end else begin
      led_cnt_q <= led_cnt_d;
      led_q     <= led_d;
    end
  end

  assign update_led = led_q;

endmodule
